// File: rtl/reg_file_if.sv
// Register-file access interface: write port, two read ports, clear sweep control.
//   master: decode side (drives addresses, enables, write data, clr)
//   slave : register file (drives busy, read data, read valids)
interface reg_file_if #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ADDR_W = 4
);
   logic              clr;
   logic              busy;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic              re_a;
   logic [ADDR_W-1:0] raddr_a;
   logic [WIDTH-1:0]  rdata_a;
   logic              rvalid_a;
   logic              re_b;
   logic [ADDR_W-1:0] raddr_b;
   logic [WIDTH-1:0]  rdata_b;
   logic              rvalid_b;

   modport master (
      output clr, we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
      input  busy, rdata_a, rvalid_a, rdata_b, rvalid_b
   );

   modport slave (
      input  clr, we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
      output busy, rdata_a, rvalid_a, rdata_b, rvalid_b
   );
endinterface

// File: rtl/reg_file_2r1w.sv
// Register file, one synchronous write port and two registered read ports.
// After reset (or a clr pulse) a hardware sweep zeroes every register, one per
// cycle, while busy=1; port activity is ignored during the sweep.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-high, highest priority
//   bus  - reg_file_if.slave: clr/busy, we/waddr/wdata,
//          re_x/raddr_x -> rdata_x/rvalid_x (x = a, b), 1-cycle read latency
module reg_file_2r1w #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned REG_NUM  = 16,
   parameter bit          ZERO_REG = 1'b0
) (
   input  logic      clk,
   input  logic      rst,
   reg_file_if.slave bus
);
   localparam int unsigned ADDR_W = $clog2(REG_NUM);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(REG_NUM - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] clr_ptr, ptr_next;
   logic              sweep_we;
   logic              wr_en;
   logic              rd_en_a, rd_en_b;
   logic [WIDTH-1:0]  rd_next_a, rd_next_b;
   logic              busy_q;
   logic              rvalid_a_q, rvalid_b_q;
   logic [WIDTH-1:0]  rdata_a_q, rdata_b_q;
   logic [WIDTH-1:0]  mem [REG_NUM];

   // Address maps onto a physical register (non power-of-two REG_NUM).
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return 32'(a) < REG_NUM;
   endfunction

   // Address that always reads as zero: unmapped, or hard-wired register 0.
   function automatic logic addr_zero(input logic [ADDR_W-1:0] a);
      return !addr_ok(a) || (ZERO_REG && (a == '0));
   endfunction

   // State register and sweep pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state   <= state_next;
         clr_ptr <= ptr_next;
      end
   end

   // Next-state logic and per-cycle port enables.
   always_comb begin
      state_next = state;
      ptr_next   = clr_ptr;
      sweep_we   = 1'b0;
      wr_en      = 1'b0;
      rd_en_a    = 1'b0;
      rd_en_b    = 1'b0;
      unique case (state)
         CLEAR: begin
            sweep_we = 1'b1;
            if (bus.clr) begin
               ptr_next = '0;
            end else if (clr_ptr == LAST_PTR) begin
               state_next = RUN;
               ptr_next   = '0;
            end else begin
               ptr_next = clr_ptr + ADDR_W'(1);
            end
         end
         RUN: begin
            if (bus.clr) begin
               state_next = CLEAR;
               ptr_next   = '0;
            end else begin
               // Dropped writes never reach the array nor the bypass path.
               wr_en   = bus.we && addr_ok(bus.waddr) &&
                         !(ZERO_REG && (bus.waddr == '0));
               rd_en_a = bus.re_a;
               rd_en_b = bus.re_b;
            end
         end
         default: state_next = CLEAR;
      endcase
   end

   // Read data selection with write-first bypass.
   always_comb begin
      rd_next_a = '0;
      if (rd_en_a && !addr_zero(bus.raddr_a)) begin
         if (wr_en && (bus.waddr == bus.raddr_a)) rd_next_a = bus.wdata;
         else                                     rd_next_a = mem[bus.raddr_a];
      end
   end

   always_comb begin
      rd_next_b = '0;
      if (rd_en_b && !addr_zero(bus.raddr_b)) begin
         if (wr_en && (bus.waddr == bus.raddr_b)) rd_next_b = bus.wdata;
         else                                     rd_next_b = mem[bus.raddr_b];
      end
   end

   // Storage array: sweep clear or normal write; frozen while rst is high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (sweep_we)   mem[clr_ptr]   <= '0;
         else if (wr_en) mem[bus.waddr] <= bus.wdata;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q     <= 1'b1;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
      end else begin
         busy_q     <= (state_next == CLEAR);
         rvalid_a_q <= rd_en_a;
         rvalid_b_q <= rd_en_b;
         rdata_a_q  <= rd_next_a;
         rdata_b_q  <= rd_next_b;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.rvalid_a = rvalid_a_q;
   assign bus.rvalid_b = rvalid_b_q;
   assign bus.rdata_a  = rdata_a_q;
   assign bus.rdata_b  = rdata_b_q;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: three instances driven in lockstep
//   inst0: REG_NUM=16 ZERO_REG=0, inst1: REG_NUM=16 ZERO_REG=1, inst2: REG_NUM=12 ZERO_REG=0
module tb_reg_file_2r1w;
   localparam int RN [3] = '{16, 16, 12};
   localparam bit ZR [3] = '{1'b0, 1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0, we = 1'b0, re_a = 1'b0, re_b = 1'b0;
   logic [3:0]  waddr = '0, raddr_a = '0, raddr_b = '0;
   logic [15:0] wdata = '0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_file_if #(.WIDTH(16), .ADDR_W(4)) if0 (), if1 (), if2 ();

   assign if0.clr = clr, if0.we = we, if0.waddr = waddr, if0.wdata = wdata,
          if0.re_a = re_a, if0.raddr_a = raddr_a, if0.re_b = re_b, if0.raddr_b = raddr_b;
   assign if1.clr = clr, if1.we = we, if1.waddr = waddr, if1.wdata = wdata,
          if1.re_a = re_a, if1.raddr_a = raddr_a, if1.re_b = re_b, if1.raddr_b = raddr_b;
   assign if2.clr = clr, if2.we = we, if2.waddr = waddr, if2.wdata = wdata,
          if2.re_a = re_a, if2.raddr_a = raddr_a, if2.re_b = re_b, if2.raddr_b = raddr_b;

   reg_file_2r1w #(.WIDTH(16), .REG_NUM(16), .ZERO_REG(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   reg_file_2r1w #(.WIDTH(16), .REG_NUM(16), .ZERO_REG(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   reg_file_2r1w #(.WIDTH(16), .REG_NUM(12), .ZERO_REG(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

   logic        busy_o [3];
   logic        rvalid_a_o [3], rvalid_b_o [3];
   logic [15:0] rdata_a_o [3], rdata_b_o [3];

   assign busy_o[0] = if0.busy, rvalid_a_o[0] = if0.rvalid_a, rvalid_b_o[0] = if0.rvalid_b,
          rdata_a_o[0] = if0.rdata_a, rdata_b_o[0] = if0.rdata_b;
   assign busy_o[1] = if1.busy, rvalid_a_o[1] = if1.rvalid_a, rvalid_b_o[1] = if1.rvalid_b,
          rdata_a_o[1] = if1.rdata_a, rdata_b_o[1] = if1.rdata_b;
   assign busy_o[2] = if2.busy, rvalid_a_o[2] = if2.rvalid_a, rvalid_b_o[2] = if2.rvalid_b,
          rdata_a_o[2] = if2.rdata_a, rdata_b_o[2] = if2.rdata_b;

   // Reference model: register contents plus remaining sweep cycles.
   logic [15:0] mdl_mem [3][16];
   int          sweep_left [3];
   logic        exp_busy [3], exp_rvalid_a [3], exp_rvalid_b [3];
   logic [15:0] exp_rdata_a [3], exp_rdata_b [3];

   function automatic logic [15:0] rd_model(int i, logic [3:0] a, bit wr_ok);
      if (int'(a) >= RN[i] || (ZR[i] && a == 4'd0)) return 16'h0000;
      if (wr_ok && waddr == a) return wdata;
      return mdl_mem[i][a];
   endfunction

   // One clock edge: model consumes the inputs present at the edge, then settle.
   task automatic step();
      bit wr_ok;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (rst || clr) begin
            for (int j = 0; j < 16; j++) mdl_mem[i][j] = 16'h0000;
            sweep_left[i] = RN[i];
            exp_rvalid_a[i] = 1'b0; exp_rdata_a[i] = 16'h0000;
            exp_rvalid_b[i] = 1'b0; exp_rdata_b[i] = 16'h0000;
         end else if (sweep_left[i] > 0) begin
            sweep_left[i]--;
            exp_rvalid_a[i] = 1'b0; exp_rdata_a[i] = 16'h0000;
            exp_rvalid_b[i] = 1'b0; exp_rdata_b[i] = 16'h0000;
         end else begin
            wr_ok = we && (int'(waddr) < RN[i]) && !(ZR[i] && waddr == 4'd0);
            exp_rvalid_a[i] = re_a;
            exp_rdata_a[i]  = re_a ? rd_model(i, raddr_a, wr_ok) : 16'h0000;
            exp_rvalid_b[i] = re_b;
            exp_rdata_b[i]  = re_b ? rd_model(i, raddr_b, wr_ok) : 16'h0000;
            if (wr_ok) mdl_mem[i][waddr] = wdata;
         end
         exp_busy[i] = (sweep_left[i] != 0);
      end
      #1;
   endtask

   task automatic idle();
      clr = 1'b0; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
   endtask

   task automatic test_reset();
      int busy_cnt [3];
      rst = 1'b1; idle(); step(); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy_o[i] !== 1'b1 || rvalid_a_o[i] !== 1'b0 || rvalid_b_o[i] !== 1'b0 ||
             rdata_a_o[i] !== 16'h0 || rdata_b_o[i] !== 16'h0) begin
            failures++;
            $display("FAIL reset_state inst%0d got busy=%b rva=%b rvb=%b rda=%h rdb=%h exp 1 0 0 0 0",
                     i, busy_o[i], rvalid_a_o[i], rvalid_b_o[i], rdata_a_o[i], rdata_b_o[i]);
         end
      end
      busy_cnt = '{default: 0};
      for (int k = 0; k < 30; k++) begin
         for (int i = 0; i < 3; i++) if (busy_o[i] === 1'b1) busy_cnt[i]++;
         step();
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy_cnt[i] != RN[i] || busy_o[i] !== 1'b0) begin
            failures++;
            $display("FAIL reset_sweep_len inst%0d got=%0d exp=%0d busy_end=%b", i, busy_cnt[i], RN[i], busy_o[i]);
         end
      end
   endtask

   task automatic test_read_all_zero(string tag);
      for (int a = 0; a < 16; a++) begin
         idle(); re_a = 1'b1; raddr_a = 4'(a); re_b = 1'b1; raddr_b = 4'(15 - a);
         step();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rvalid_a_o[i] !== 1'b1 || rvalid_b_o[i] !== 1'b1 ||
                rdata_a_o[i] !== 16'h0 || rdata_b_o[i] !== 16'h0) begin
               failures++;
               $display("FAIL %s inst%0d addr=%0d got rva=%b rda=%h rvb=%b rdb=%h exp 1 0000 1 0000",
                        tag, i, a, rvalid_a_o[i], rdata_a_o[i], rvalid_b_o[i], rdata_b_o[i]);
            end
         end
      end
      idle();
   endtask

   task automatic test_write_read();
      idle(); we = 1'b1; waddr = 4'd5; wdata = 16'hBEEF; step();
      idle(); re_a = 1'b1; raddr_a = 4'd5; step();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rdata_a_o[i] !== 16'hBEEF || rvalid_a_o[i] !== 1'b1 ||
             rdata_b_o[i] !== 16'h0 || rvalid_b_o[i] !== 1'b0) begin
            failures++;
            $display("FAIL write_read inst%0d got rda=%h rva=%b rdb=%h rvb=%b exp BEEF 1 0000 0",
                     i, rdata_a_o[i], rvalid_a_o[i], rdata_b_o[i], rvalid_b_o[i]);
         end
      end
      idle();
   endtask

   task automatic test_bypass();
      idle(); we = 1'b1; waddr = 4'd3; wdata = 16'h1234;
      re_a = 1'b1; raddr_a = 4'd3; re_b = 1'b1; raddr_b = 4'd3; step();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rdata_a_o[i] !== 16'h1234 || rdata_b_o[i] !== 16'h1234 ||
             rvalid_a_o[i] !== 1'b1 || rvalid_b_o[i] !== 1'b1) begin
            failures++;
            $display("FAIL bypass inst%0d got rda=%h rdb=%h exp 1234 1234", i, rdata_a_o[i], rdata_b_o[i]);
         end
      end
      idle();
   endtask

   task automatic test_zero_reg();
      logic [15:0] exp;
      idle(); we = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; re_a = 1'b1; raddr_a = 4'd0; step();
      for (int i = 0; i < 3; i++) begin
         exp = ZR[i] ? 16'h0000 : 16'hFFFF;
         checks++;
         if (rdata_a_o[i] !== exp || rvalid_a_o[i] !== 1'b1) begin
            failures++;
            $display("FAIL zero_reg_bypass inst%0d got=%h exp=%h", i, rdata_a_o[i], exp);
         end
      end
      idle(); re_b = 1'b1; raddr_b = 4'd0; step();
      for (int i = 0; i < 3; i++) begin
         exp = ZR[i] ? 16'h0000 : 16'hFFFF;
         checks++;
         if (rdata_b_o[i] !== exp || rvalid_b_o[i] !== 1'b1) begin
            failures++;
            $display("FAIL zero_reg_read inst%0d got=%h exp=%h", i, rdata_b_o[i], exp);
         end
      end
      idle();
   endtask

   task automatic test_out_of_range();
      logic [15:0] exp;
      idle(); we = 1'b1; waddr = 4'd13; wdata = 16'hAAAA; re_a = 1'b1; raddr_a = 4'd13; step();
      idle(); re_b = 1'b1; raddr_b = 4'd13;
      for (int i = 0; i < 3; i++) begin
         exp = (RN[i] <= 13) ? 16'h0000 : 16'hAAAA;
         checks++;
         if (rdata_a_o[i] !== exp || rvalid_a_o[i] !== 1'b1) begin
            failures++;
            $display("FAIL oor_bypass inst%0d got=%h rv=%b exp=%h 1", i, rdata_a_o[i], rvalid_a_o[i], exp);
         end
      end
      step();
      for (int i = 0; i < 3; i++) begin
         exp = (RN[i] <= 13) ? 16'h0000 : 16'hAAAA;
         checks++;
         if (rdata_b_o[i] !== exp || rvalid_b_o[i] !== 1'b1) begin
            failures++;
            $display("FAIL oor_read inst%0d got=%h rv=%b exp=%h 1", i, rdata_b_o[i], rvalid_b_o[i], exp);
         end
      end
      idle();
   endtask

   task automatic test_clear();
      int busy_cnt [3];
      for (int a = 1; a < 16; a++) begin
         idle(); we = 1'b1; waddr = 4'(a); wdata = 16'($urandom) | 16'h0001; step();
      end
      idle(); clr = 1'b1; re_a = 1'b1; raddr_a = 4'd7; step(); clr = 1'b0;
      busy_cnt = '{default: 0};
      for (int k = 0; k < 30; k++) begin
         for (int i = 0; i < 3; i++) begin
            if (busy_o[i] === 1'b1) begin
               busy_cnt[i]++;
               checks++;
               if (rvalid_a_o[i] !== 1'b0) begin
                  failures++;
                  $display("FAIL clear_read_blocked inst%0d cyc%0d got rvalid=%b exp 0", i, k, rvalid_a_o[i]);
               end
            end
         end
         re_a = 1'b1; raddr_a = 4'($urandom_range(0, 15));
         step();
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy_cnt[i] != RN[i]) begin
            failures++;
            $display("FAIL clear_sweep_len inst%0d got=%0d exp=%0d", i, busy_cnt[i], RN[i]);
         end
      end
      test_read_all_zero("clear_readback");
   endtask

   task automatic test_rst_mid_sweep();
      int busy_cnt [3];
      idle(); re_a = 1'b1; raddr_a = 4'd5; rst = 1'b1; step(); rst = 1'b0; idle();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rvalid_a_o[i] !== 1'b0 || busy_o[i] !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_read inst%0d got rva=%b busy=%b exp 0 1", i, rvalid_a_o[i], busy_o[i]);
         end
      end
      repeat (5) step();
      rst = 1'b1; step(); rst = 1'b0;
      busy_cnt = '{default: 0};
      for (int k = 0; k < 30; k++) begin
         for (int i = 0; i < 3; i++) if (busy_o[i] === 1'b1) busy_cnt[i]++;
         step();
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy_cnt[i] != RN[i]) begin
            failures++;
            $display("FAIL rst_mid_sweep_len inst%0d got=%0d exp=%0d", i, busy_cnt[i], RN[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         rst     = ($urandom_range(0, 199) == 0);
         clr     = ($urandom_range(0, 59) == 0);
         we      = 1'($urandom);
         waddr   = 4'($urandom_range(0, 15));
         wdata   = 16'($urandom);
         re_a    = 1'($urandom);
         re_b    = 1'($urandom);
         raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
         raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 4'($urandom_range(0, 15));
         step();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy_o[i], rvalid_a_o[i], rdata_a_o[i], rvalid_b_o[i], rdata_b_o[i]} !==
                {exp_busy[i], exp_rvalid_a[i], exp_rdata_a[i], exp_rvalid_b[i], exp_rdata_b[i]}) begin
               failures++;
               $display("FAIL random cyc%0d inst%0d got busy=%b rva=%b rda=%h rvb=%b rdb=%h exp %b %b %h %b %h",
                        k, i, busy_o[i], rvalid_a_o[i], rdata_a_o[i], rvalid_b_o[i], rdata_b_o[i],
                        exp_busy[i], exp_rvalid_a[i], exp_rdata_a[i], exp_rvalid_b[i], exp_rdata_b[i]);
            end
         end
      end
      rst = 1'b0; idle();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_read_all_zero("reset_readback");
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_out_of_range();
      test_clear();
      test_rst_mid_sweep();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
